// File: rtl/median_iter_sched.sv
// Loop scheduler for the quickselect median pipeline: gathers one token set,
// then either forwards it for another partition pass or emits the final median.
module median_iter_sched #(
  parameter logic [10:0] BUFF_SIZE     = 11'd16,
  parameter int          BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1,
  parameter logic [7:0]  MAX_ITER      = 8'd16,
  parameter int          ITER_BIT      = 8
) (
  input  logic                     clock,
  input  logic                     reset,

  input  logic [7:0]               in_pivot,
  output logic                     in_pivot_rd,
  input  logic                     in_pivot_empty,
  input  logic [BUFF_SIZE_BIT-1:0] in_buff_size,
  output logic                     in_buff_size_rd,
  input  logic                     in_buff_size_empty,
  input  logic [BUFF_SIZE_BIT-1:0] in_median_pos,
  output logic                     in_median_pos_rd,
  input  logic                     in_median_pos_empty,
  input  logic [7:0]               in_second_median_value,
  output logic                     in_second_median_value_rd,
  input  logic                     in_second_median_value_empty,

  output logic [7:0]               out_pivot,
  output logic                     out_pivot_wr,
  input  logic                     out_pivot_full,
  output logic [BUFF_SIZE_BIT-1:0] out_buff_size,
  output logic                     out_buff_size_wr,
  input  logic                     out_buff_size_full,
  output logic [BUFF_SIZE_BIT-1:0] out_median_pos,
  output logic                     out_median_pos_wr,
  input  logic                     out_median_pos_full,
  output logic [7:0]               out_second_median_value,
  output logic                     out_second_median_value_wr,
  input  logic                     out_second_median_value_full,

  output logic [7:0]               out_median,
  output logic                     out_median_wr,
  input  logic                     out_median_full,
  output logic                     out_median_err,

  output logic [ITER_BIT-1:0]      iter_count,
  output logic                     busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECIDE,
    S_FWD,
    S_EMIT
  } state_t;

  localparam logic [ITER_BIT-1:0] ITER_SAT   = {ITER_BIT{1'b1}};
  localparam logic [ITER_BIT-1:0] ITER_LIMIT = ITER_BIT'(MAX_ITER);

  function automatic logic [ITER_BIT-1:0] sat_inc(input logic [ITER_BIT-1:0] v);
    return (v == ITER_SAT) ? v : v + ITER_BIT'(1);
  endfunction

  state_t                     state_q, state_d;
  logic [7:0]                 pivot_tok_q, pivot_tok_d;
  logic [BUFF_SIZE_BIT-1:0]   size_tok_q, size_tok_d;
  logic [BUFF_SIZE_BIT-1:0]   pos_tok_q, pos_tok_d;
  logic [7:0]                 smv_tok_q, smv_tok_d;
  logic [7:0]                 med_sel_q, med_sel_d;
  logic                       err_sel_q, err_sel_d;
  logic [7:0]                 out_pivot_q, out_pivot_d;
  logic [BUFF_SIZE_BIT-1:0]   out_buff_size_q, out_buff_size_d;
  logic [BUFF_SIZE_BIT-1:0]   out_median_pos_q, out_median_pos_d;
  logic [7:0]                 out_smv_q, out_smv_d;
  logic                       fwd_wr_q, fwd_wr_d;
  logic [7:0]                 out_median_q, out_median_d;
  logic                       out_median_err_q, out_median_err_d;
  logic                       med_wr_q, med_wr_d;
  logic [ITER_BIT-1:0]        iter_q, iter_d;

  logic rd_all;
  logic out_ready;
  logic fwd_fire;
  logic emit_fire;

  // A token set is consumed only when all four FIFOs can supply at once.
  assign rd_all = reset & (state_q == S_IDLE) & ~in_pivot_empty & ~in_buff_size_empty
                & ~in_median_pos_empty & ~in_second_median_value_empty;
  assign out_ready = ~(out_pivot_full | out_buff_size_full | out_median_pos_full
                     | out_second_median_value_full);

  assign in_pivot_rd               = rd_all;
  assign in_buff_size_rd           = rd_all;
  assign in_median_pos_rd          = rd_all;
  assign in_second_median_value_rd = rd_all;

  always_comb begin
    state_d          = state_q;
    pivot_tok_d      = pivot_tok_q;
    size_tok_d       = size_tok_q;
    pos_tok_d        = pos_tok_q;
    smv_tok_d        = smv_tok_q;
    med_sel_d        = med_sel_q;
    err_sel_d        = err_sel_q;
    out_pivot_d      = out_pivot_q;
    out_buff_size_d  = out_buff_size_q;
    out_median_pos_d = out_median_pos_q;
    out_smv_d        = out_smv_q;
    fwd_wr_d         = 1'b0;
    out_median_d     = out_median_q;
    out_median_err_d = out_median_err_q;
    med_wr_d         = 1'b0;
    iter_d           = iter_q;
    fwd_fire         = 1'b0;
    emit_fire        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rd_all) begin
          pivot_tok_d = in_pivot;
          size_tok_d  = in_buff_size;
          pos_tok_d   = in_median_pos;
          smv_tok_d   = in_second_median_value;
          state_d     = S_DECIDE;
        end
      end
      S_DECIDE: begin
        if (size_tok_q == '0) begin
          med_sel_d = pivot_tok_q;
          err_sel_d = 1'b0;
          state_d   = S_EMIT;
        end else if (pos_tok_q >= size_tok_q) begin
          med_sel_d = pivot_tok_q;
          err_sel_d = 1'b1;
          state_d   = S_EMIT;
        end else if (iter_q == ITER_LIMIT) begin
          // Runaway frame: fall back to the second median candidate.
          med_sel_d = smv_tok_q;
          err_sel_d = 1'b1;
          state_d   = S_EMIT;
        end else begin
          state_d   = S_FWD;
        end
        fwd_fire  = (state_d == S_FWD) && out_ready;
        emit_fire = (state_d == S_EMIT) && !out_median_full;
      end
      S_FWD: begin
        if (fwd_wr_q) state_d = S_IDLE;
        else          fwd_fire = out_ready;
      end
      S_EMIT: begin
        if (med_wr_q) state_d = S_IDLE;
        else          emit_fire = !out_median_full;
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered, so the write is launched at the edge where full is seen low.
    if (fwd_fire) begin
      fwd_wr_d         = 1'b1;
      out_pivot_d      = pivot_tok_q;
      out_buff_size_d  = size_tok_q;
      out_median_pos_d = pos_tok_q;
      out_smv_d        = smv_tok_q;
      iter_d           = sat_inc(iter_q);
    end
    if (emit_fire) begin
      med_wr_d         = 1'b1;
      out_median_d     = med_sel_d;
      out_median_err_d = err_sel_d;
      iter_d           = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      pivot_tok_q      <= '0;
      size_tok_q       <= '0;
      pos_tok_q        <= '0;
      smv_tok_q        <= '0;
      med_sel_q        <= '0;
      err_sel_q        <= 1'b0;
      out_pivot_q      <= '0;
      out_buff_size_q  <= '0;
      out_median_pos_q <= '0;
      out_smv_q        <= '0;
      fwd_wr_q         <= 1'b0;
      out_median_q     <= '0;
      out_median_err_q <= 1'b0;
      med_wr_q         <= 1'b0;
      iter_q           <= '0;
    end else begin
      state_q          <= state_d;
      pivot_tok_q      <= pivot_tok_d;
      size_tok_q       <= size_tok_d;
      pos_tok_q        <= pos_tok_d;
      smv_tok_q        <= smv_tok_d;
      med_sel_q        <= med_sel_d;
      err_sel_q        <= err_sel_d;
      out_pivot_q      <= out_pivot_d;
      out_buff_size_q  <= out_buff_size_d;
      out_median_pos_q <= out_median_pos_d;
      out_smv_q        <= out_smv_d;
      fwd_wr_q         <= fwd_wr_d;
      out_median_q     <= out_median_d;
      out_median_err_q <= out_median_err_d;
      med_wr_q         <= med_wr_d;
      iter_q           <= iter_d;
    end
  end

  assign out_pivot                  = out_pivot_q;
  assign out_buff_size              = out_buff_size_q;
  assign out_median_pos             = out_median_pos_q;
  assign out_second_median_value    = out_smv_q;
  assign out_pivot_wr               = fwd_wr_q;
  assign out_buff_size_wr           = fwd_wr_q;
  assign out_median_pos_wr          = fwd_wr_q;
  assign out_second_median_value_wr = fwd_wr_q;
  assign out_median                 = out_median_q;
  assign out_median_wr              = med_wr_q;
  assign out_median_err             = out_median_err_q;
  assign iter_count                 = iter_q;
  assign busy                       = (state_q != S_IDLE);

endmodule

// File: tb/tb_median_iter_sched.sv
// Scoreboard bench for median_iter_sched: directed token sets with expected
// forward/emit responses queued at issue time and checked by a monitor.
module tb_median_iter_sched;

  localparam int BSB = 5;

  logic           clock = 1'b0;
  logic           reset;
  logic [7:0]     in_pivot;
  logic           in_pivot_rd, in_pivot_empty;
  logic [BSB-1:0] in_buff_size;
  logic           in_buff_size_rd, in_buff_size_empty;
  logic [BSB-1:0] in_median_pos;
  logic           in_median_pos_rd, in_median_pos_empty;
  logic [7:0]     in_smv;
  logic           in_smv_rd, in_smv_empty;
  logic [7:0]     out_pivot;
  logic           out_pivot_wr, out_pivot_full;
  logic [BSB-1:0] out_buff_size;
  logic           out_buff_size_wr, out_buff_size_full;
  logic [BSB-1:0] out_median_pos;
  logic           out_median_pos_wr, out_median_pos_full;
  logic [7:0]     out_smv;
  logic           out_smv_wr, out_smv_full;
  logic [7:0]     out_median;
  logic           out_median_wr, out_median_full, out_median_err;
  logic [7:0]     iter_count;
  logic           busy;

  median_iter_sched dut (
    .clock(clock), .reset(reset),
    .in_pivot(in_pivot), .in_pivot_rd(in_pivot_rd), .in_pivot_empty(in_pivot_empty),
    .in_buff_size(in_buff_size), .in_buff_size_rd(in_buff_size_rd),
    .in_buff_size_empty(in_buff_size_empty),
    .in_median_pos(in_median_pos), .in_median_pos_rd(in_median_pos_rd),
    .in_median_pos_empty(in_median_pos_empty),
    .in_second_median_value(in_smv), .in_second_median_value_rd(in_smv_rd),
    .in_second_median_value_empty(in_smv_empty),
    .out_pivot(out_pivot), .out_pivot_wr(out_pivot_wr), .out_pivot_full(out_pivot_full),
    .out_buff_size(out_buff_size), .out_buff_size_wr(out_buff_size_wr),
    .out_buff_size_full(out_buff_size_full),
    .out_median_pos(out_median_pos), .out_median_pos_wr(out_median_pos_wr),
    .out_median_pos_full(out_median_pos_full),
    .out_second_median_value(out_smv), .out_second_median_value_wr(out_smv_wr),
    .out_second_median_value_full(out_smv_full),
    .out_median(out_median), .out_median_wr(out_median_wr),
    .out_median_full(out_median_full), .out_median_err(out_median_err),
    .iter_count(iter_count), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]     p;
    logic [BSB-1:0] s;
    logic [BSB-1:0] m;
    logic [7:0]     v;
    logic [7:0]     it;
  } fwd_t;

  typedef struct {
    logic [7:0] med;
    logic       err;
  } med_t;

  fwd_t fwd_q[$];
  med_t med_q[$];

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int fwd_cnt = 0;
  int last_fwd_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clock) begin
    if (out_pivot_wr | out_buff_size_wr | out_median_pos_wr | out_smv_wr) begin
      fwd_t e;
      chk("fwd_wr_together", {28'd0, out_pivot_wr, out_buff_size_wr, out_median_pos_wr, out_smv_wr}, 32'hF);
      if (fwd_q.size() == 0) begin
        chk("fwd_unexpected_wr", 32'd1, 32'd0);
      end else begin
        e = fwd_q.pop_front();
        chk("fwd_pivot", {24'd0, out_pivot}, {24'd0, e.p});
        chk("fwd_buff_size", {27'd0, out_buff_size}, {27'd0, e.s});
        chk("fwd_median_pos", {27'd0, out_median_pos}, {27'd0, e.m});
        chk("fwd_smv", {24'd0, out_smv}, {24'd0, e.v});
        chk("fwd_iter_count", {24'd0, iter_count}, {24'd0, e.it});
      end
      fwd_cnt++;
      last_fwd_cyc = cyc;
    end
    if (out_median_wr) begin
      med_t e;
      if (med_q.size() == 0) begin
        chk("med_unexpected_wr", 32'd1, 32'd0);
      end else begin
        e = med_q.pop_front();
        chk("med_value", {24'd0, out_median}, {24'd0, e.med});
        chk("med_err", {31'd0, out_median_err}, {31'd0, e.err});
        chk("med_iter_cleared", {24'd0, iter_count}, 32'd0);
      end
    end
  end

  task automatic set_empty(input logic e);
    in_pivot_empty = e; in_buff_size_empty = e; in_median_pos_empty = e; in_smv_empty = e;
  endtask

  // kind: 0 = no response expected, 1 = forward, 2 = emit
  task automatic push_set(input logic [7:0] p, input logic [BSB-1:0] s, input logic [BSB-1:0] m,
                          input logic [7:0] v, input int kind, input logic [7:0] exp_med,
                          input logic exp_err, input logic [7:0] exp_it, output int rd_cyc);
    fwd_t f;
    med_t d;
    int   waited;
    if (kind == 1) begin
      f.p = p; f.s = s; f.m = m; f.v = v; f.it = exp_it;
      fwd_q.push_back(f);
    end else if (kind == 2) begin
      d.med = exp_med; d.err = exp_err;
      med_q.push_back(d);
    end
    @(negedge clock);
    in_pivot = p; in_buff_size = s; in_median_pos = m; in_smv = v;
    set_empty(1'b0);
    #1;
    waited = 0;
    while (!in_pivot_rd && waited < 200) begin
      @(negedge clock); #1;
      waited++;
    end
    rd_cyc = cyc;
    if (!in_pivot_rd) begin
      chk("rd_timeout", 32'd0, 32'd1);
    end else begin
      chk("rd_together", {28'd0, in_pivot_rd, in_buff_size_rd, in_median_pos_rd, in_smv_rd}, 32'hF);
      @(posedge clock); #1;
    end
    set_empty(1'b1);
  endtask

  task automatic wait_drain();
    int waited = 0;
    while ((fwd_q.size() + med_q.size()) != 0 && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    chk("drain_pending", fwd_q.size() + med_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int rc;
    int base;
    reset = 1'b0;
    in_pivot = 8'd1; in_buff_size = 5'd4; in_median_pos = 5'd1; in_smv = 8'd2;
    set_empty(1'b0);
    out_pivot_full = 1'b0; out_buff_size_full = 1'b0; out_median_pos_full = 1'b0;
    out_smv_full = 1'b0; out_median_full = 1'b0;

    // Reset state, with every input FIFO non-empty: reads must stay masked.
    repeat (3) @(negedge clock);
    chk("rst_rd", {31'd0, in_pivot_rd}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_iter", {24'd0, iter_count}, 32'd0);
    chk("rst_wr", {30'd0, out_pivot_wr, out_median_wr}, 32'd0);
    chk("rst_data", {out_median, out_pivot, 7'd0, out_median_err, 3'd0, out_buff_size}, 32'd0);
    set_empty(1'b1);
    reset = 1'b1;

    // Partial token set is never consumed.
    @(negedge clock);
    in_pivot_empty = 1'b0; in_buff_size_empty = 1'b0; in_smv_empty = 1'b0;
    repeat (3) @(negedge clock);
    chk("partial_no_rd", {31'd0, in_pivot_rd | in_buff_size_rd | in_smv_rd}, 32'd0);
    set_empty(1'b1);

    // Plain forward with minimum latency.
    push_set(8'd127, 5'd16, 5'd8, 8'd127, 1, 8'd0, 1'b0, 8'd1, rc);
    chk("decide_busy", {31'd0, busy}, 32'd1);
    wait_drain();
    chk("fwd_latency", last_fwd_cyc - rc, 32'd2);

    // buff_size==0: median found.
    base = fwd_cnt;
    push_set(8'd93, 5'd0, 5'd3, 8'd90, 2, 8'd93, 1'b0, 8'd0, rc);
    wait_drain();
    chk("found_no_fwd", fwd_cnt - base, 32'd0);

    // Back-pressure on one forward FIFO.
    out_buff_size_full = 1'b1;
    push_set(8'd50, 5'd10, 5'd2, 8'd40, 1, 8'd0, 1'b0, 8'd1, rc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("bp_no_wr", {31'd0, out_pivot_wr | out_buff_size_wr}, 32'd0);
      chk("bp_no_rd", {31'd0, in_pivot_rd}, 32'd0);
      chk("bp_hold_data", {out_pivot, 3'd0, out_buff_size}, {8'd127, 8'd16});
    end
    out_buff_size_full = 1'b0;
    @(negedge clock);
    chk("bp_release_wr", {30'd0, out_pivot_wr, out_buff_size_wr}, 32'd3);
    wait_drain();

    // Runaway frame: 16 forwards then forced termination on the 17th.
    push_set(8'd10, 5'd0, 5'd0, 8'd10, 2, 8'd10, 1'b0, 8'd0, rc);
    wait_drain();
    base = fwd_cnt;
    for (int i = 0; i < 16; i++)
      push_set(8'(i + 1), 5'd8, 5'd3, 8'(100 + i), 1, 8'd0, 1'b0, 8'(i + 1), rc);
    push_set(8'd200, 5'd4, 5'd1, 8'd55, 2, 8'd55, 1'b1, 8'd0, rc);
    wait_drain();
    chk("runaway_fwd_count", fwd_cnt - base, 32'd16);

    // Corrupt rank.
    push_set(8'd77, 5'd8, 5'd9, 8'd66, 2, 8'd77, 1'b1, 8'd0, rc);
    wait_drain();

    // Reset during a stalled forward drops the set silently.
    push_set(8'd60, 5'd8, 5'd2, 8'd61, 1, 8'd0, 1'b0, 8'd1, rc);
    wait_drain();
    out_pivot_full = 1'b1;
    push_set(8'd33, 5'd8, 5'd2, 8'd44, 0, 8'd0, 1'b0, 8'd0, rc);
    repeat (2) @(negedge clock);
    chk("stall_busy", {31'd0, busy}, 32'd1);
    chk("stall_iter", {24'd0, iter_count}, 32'd1);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_iter", {24'd0, iter_count}, 32'd0);
    chk("midrst_wr", {31'd0, out_pivot_wr}, 32'd0);
    chk("midrst_data", {24'd0, out_pivot}, 32'd0);
    reset = 1'b1;
    out_pivot_full = 1'b0;
    repeat (6) @(negedge clock);
    chk("post_rst_idle", {31'd0, busy}, 32'd0);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/median_iter_sched.md
Name: median_iter_sched

Overview:
- Loop scheduler for the quickselect median pipeline.
- Collects one parameter token set (pivot, buff_size, median_pos, second_median_value) from the first actor or the shared iteration actor (merged upstream into one FIFO per token).
- Decides per pass: forward the set to the iteration actor for another pass, or emit the final median.
- Bounds iteration count and flags corrupt or runaway frames.

Parameters:
- BUFF_SIZE, 11'd16: original buffer size; sets BUFF_SIZE_BIT.
- BUFF_SIZE_BIT, $clog2(BUFF_SIZE)+1: width of the buff_size and median_pos tokens.
- MAX_ITER, 8'd16: maximum forwarded passes per frame before forced termination.
- ITER_BIT, 8: width of the iteration counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- in_pivot / in_pivot_rd / in_pivot_empty  in/out/in  8/1/1  pivot token FIFO.
- in_buff_size / in_buff_size_rd / in_buff_size_empty  in/out/in  BUFF_SIZE_BIT/1/1  remaining partition size; 0 means median found.
- in_median_pos / in_median_pos_rd / in_median_pos_empty  in/out/in  BUFF_SIZE_BIT/1/1  target rank within the partition.
- in_second_median_value / _rd / _empty  in/out/in  8/1/1  second median candidate.
- out_pivot / out_pivot_wr / out_pivot_full  out/out/in  8/1/1  to iteration actor.
- out_buff_size / _wr / _full  out/out/in  BUFF_SIZE_BIT/1/1  to iteration actor.
- out_median_pos / _wr / _full  out/out/in  BUFF_SIZE_BIT/1/1  to iteration actor.
- out_second_median_value / _wr / _full  out/out/in  8/1/1  to iteration actor.
- out_median / out_median_wr / out_median_full  out/out/in  8/1/1  final median result.
- out_median_err  out  1  qualified by out_median_wr; 1 = forced or corrupt termination.
- iter_count  out  ITER_BIT  passes forwarded in the current frame.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE; all *_wr 0; all data outputs 0; out_median_err 0; iter_count 0; busy 0; captured tokens discarded.
- All *_rd are combinational: in_*_rd = (state==IDLE) & ~in_pivot_empty & ~in_buff_size_empty & ~in_median_pos_empty & ~in_second_median_value_empty.
  - All four reads assert in the same cycle; a partial set is never consumed.
  - *_rd is forced to 0 while reset==0.
- FSM states: IDLE, DECIDE, FWD, EMIT.
  - IDLE: when the read condition holds, register all four tokens and go to DECIDE.
  - DECIDE (1 cycle), in priority order:
    - buff_size==0: go to EMIT, err=0, median=pivot.
    - median_pos >= buff_size: go to EMIT, err=1, median=pivot.
    - iter_count==MAX_ITER: go to EMIT, err=1, median=second_median_value.
    - Otherwise go to FWD.
  - FWD: wait until all four out_*_full are 0.
    - Then assert all four out_*_wr for exactly one cycle, with data equal to the registered tokens, unmodified.
    - Same cycle: iter_count += 1, saturating at 2^ITER_BIT-1. Next state IDLE.
  - EMIT: wait until out_median_full==0.
    - Then out_median_wr=1 for one cycle, with out_median and out_median_err valid.
    - Same cycle: iter_count cleared to 0. Next state IDLE.
- Wr strobes and data outputs are registered.
  - Minimum latency: rd at cycle T, DECIDE at T+1, wr at T+2.
  - Minimum spacing between consecutive token-set reads is 3 cycles.
- Full back-pressure:
  - Data outputs stay stable while waiting in FWD or EMIT.
  - wr is never asserted while the corresponding full is high.
  - No new input is read until the pending write completes.
- A full deasserting in the same cycle the FSM enters FWD or EMIT counts as ready at the next edge.
- Data outputs hold their last written values between writes.
- Reset asserted mid-pass (any state): the next edge returns to IDLE with no wr pulse, and the in-flight token set is lost.

Test Plan:
- Reset then apply set {pivot=127, buff_size=16, median_pos=8, smv=127} -> rd pulse at cycle T; all four out_*_wr at T+2 with identical values; iter_count=1.
- Set {pivot=93, buff_size=0, median_pos=3, smv=90} -> out_median_wr=1 with out_median=93, out_median_err=0; no out_*_wr to the iteration actor; iter_count returns to 0.
- Hold out_buff_size_full=1 for 5 cycles during FWD -> no out_*_wr, outputs stable and in_*_rd=0 throughout; all four wr fire one cycle after full drops.
- Feed 16 forwarded passes, then a 17th set with buff_size=4, median_pos=1, smv=55 -> out_median=55, out_median_err=1, and only 16 FWD writes observed.
- Set with median_pos=9, buff_size=8 -> EMIT with out_median_err=1, out_median=pivot; apply reset==0 during a later FWD wait -> no wr pulse, state IDLE, iter_count=0.
